// File: rtl/round_seq_pkg.sv
// Shared types and default sizing for the permutation round sequencer.
package round_seq_pkg;

  localparam int unsigned NROUNDS_DEF = 24;
  localparam int unsigned NSTEPS_DEF  = 5;
  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FINISH  = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  // Engine slot order within one round
  typedef enum logic [2:0] {
    STEP_THETA = 3'd0,
    STEP_RHO   = 3'd1,
    STEP_PI    = 3'd2,
    STEP_CHI   = 3'd3,
    STEP_IOTA  = 3'd4
  } step_e;

endpackage

// File: rtl/step_watchdog.sv
// Per-step cycle counter; expire_c flags the last permitted WAIT cycle.
module step_watchdog
  import round_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TW      = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_c = (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/round_sequencer.sv
// Round/step scheduler: launches each step engine in order, tracks the
// ping-pong bank and round index, and faults on an unresponsive engine.
module round_sequencer
  import round_seq_pkg::*;
#(
  parameter int unsigned NROUNDS = NROUNDS_DEF,
  parameter int unsigned NSTEPS  = NSTEPS_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned RW      = 5,
  parameter int unsigned SW      = 3,
  parameter int unsigned TW      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NSTEPS-1:0] step_done,
  output logic [NSTEPS-1:0] step_start,
  output logic [RW-1:0]     round,
  output logic [SW-1:0]     step,
  output logic              bank_sel,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  localparam logic [SW-1:0] LAST_STEP  = SW'(NSTEPS - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(NROUNDS - 1);

  state_e            state_q, state_d;
  logic [RW-1:0]     round_q, round_d;
  logic [SW-1:0]     step_q, step_d;
  logic              bank_q, bank_d;
  logic [NSTEPS-1:0] step_start_q, step_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              wd_clr_c, wd_en_c, wd_expire_c, done_hit_c;

  function automatic logic [NSTEPS-1:0] step_onehot(input logic [SW-1:0] idx);
    return NSTEPS'(1) << idx;
  endfunction

  step_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (wd_clr_c),
    .en       (wd_en_c),
    .expire_c (wd_expire_c)
  );

  // Next state, index/bank updates and next registered outputs
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    step_d       = step_q;
    bank_d       = bank_q;
    wd_clr_c     = 1'b0;
    wd_en_c      = 1'b0;
    step_start_d = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    fault_d      = 1'b0;
    done_hit_c   = |(step_done & step_onehot(step_q));

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LAUNCH;
          round_d = '0;
          step_d  = '0;
          bank_d  = 1'b0;
        end
      end
      ST_LAUNCH: begin
        wd_clr_c = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // A done in the expiring cycle still counts as a completion
        if (done_hit_c) begin
          state_d = ST_ADVANCE;
        end else if (wd_expire_c) begin
          state_d = ST_FAULT;
        end else begin
          wd_en_c = 1'b1;
        end
      end
      ST_ADVANCE: begin
        bank_d = ~bank_q;
        if (step_q < LAST_STEP) begin
          step_d  = step_q + SW'(1);
          state_d = ST_LAUNCH;
        end else if (round_q < LAST_ROUND) begin
          step_d  = '0;
          round_d = round_q + RW'(1);
          state_d = ST_LAUNCH;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      round_d  = '0;
      step_d   = '0;
      bank_d   = 1'b0;
      wd_clr_c = 1'b1;
    end

    // Outputs are registered against the state being entered
    if (state_d == ST_LAUNCH) begin
      step_start_d = step_onehot(step_d);
    end
    busy_d  = (state_d == ST_LAUNCH) || (state_d == ST_WAIT) ||
              (state_d == ST_ADVANCE) || (state_d == ST_FINISH);
    done_d  = (state_d == ST_FINISH);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      round_q      <= '0;
      step_q       <= '0;
      bank_q       <= 1'b0;
      step_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      step_q       <= step_d;
      bank_q       <= bank_d;
      step_start_q <= step_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
    end
  end

  assign step_start = step_start_q;
  assign round      = round_q;
  assign step       = step_q;
  assign bank_sel   = bank_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Top-level scheduler for the 5x5-lane permutation datapath.
- Runs NROUNDS rounds. Each round fires NSTEPS step engines in fixed order 0..NSTEPS-1, using a one-cycle start pulse and a done pulse per engine. Typical engines: column parity, rotate, permute, re-evaluate, round-constant add.
- Sits between the host start/done handshake and the per-step controllers.
- Also owns the ping-pong state-memory bank select, the round index used for constant lookup, and a per-step watchdog.

Parameters:
- NROUNDS, 24, number of rounds per permutation.
- NSTEPS, 5, number of step engines per round.
- TIMEOUT, 1024, maximum WAIT cycles per step before fault.
- RW, 5, round index width; must satisfy 2^RW >= NROUNDS.
- SW, 3, step index width; must satisfy 2^SW >= NSTEPS.
- TW, 11, watchdog width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  host request; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority after rst.
- step_done  in  NSTEPS  done pulses, one bit per engine.
- step_start  out  NSTEPS  one-hot, one-cycle start pulse to the current engine.
- round  out  RW  current round index, 0..NROUNDS-1.
- step  out  SW  current step index, 0..NSTEPS-1.
- bank_sel  out  1  source bank for the current step; the destination is ~bank_sel.
- busy  out  1  high in LAUNCH, WAIT, ADVANCE, FINISH.
- done  out  1  one-cycle pulse when the permutation completes.
- fault  out  1  watchdog expired; held until abort or rst.

Behaviour:
- Reset: state=IDLE; round=0, step=0, bank_sel=0, watchdog=0. All outputs 0.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- IDLE:
  - start=1 -> LAUNCH; clear round, step, bank_sel to 0.
  - Otherwise stay in IDLE.
- LAUNCH (1 cycle):
  - step_start[step]=1; all other bits 0.
  - Clear watchdog; go to WAIT.
  - step_done is ignored in this cycle.
- WAIT:
  - step_done[step]=1 -> ADVANCE.
  - Otherwise increment the watchdog. If it equals TIMEOUT-1 in a cycle without done -> FAULT.
  - done and timeout in the same cycle: done wins.
  - step_done bits other than [step] are ignored.
- ADVANCE (1 cycle):
  - Toggle bank_sel.
  - If step<NSTEPS-1: step+1 -> LAUNCH.
  - Else if round<NROUNDS-1: step=0, round+1 -> LAUNCH.
  - Else -> FINISH, with round and step left at their final values.
- FINISH (1 cycle): done=1 -> IDLE. round, step and bank_sel hold until the next start.
- FAULT:
  - fault=1, busy=0; round and step freeze for debug.
  - Only abort or rst leave FAULT. start is ignored.
- abort=1 in any state:
  - Next state is IDLE; round, step, bank_sel and fault are cleared.
  - No done pulse. step_start is forced to 0 in the abort cycle.
- Cycle count when every engine answers on its first WAIT cycle:
  - 3 cycles per step; done is asserted NROUNDS*NSTEPS*3+1 cycles after the start edge.
  - Final bank_sel = (NROUNDS*NSTEPS) mod 2, which selects the result bank.
- start while busy is ignored; it is not queued.

Decomposition:
- Package round_seq_pkg holds:
  - the state encoding: IDLE, LAUNCH, WAIT, ADVANCE, FINISH, FAULT (3-bit);
  - the default NROUNDS/NSTEPS/TIMEOUT constants;
  - the step-index constants for the five engines.
- One sub-module, step_watchdog: a TW-bit counter with clr, en and an expire flag (count==TIMEOUT-1).
- The FSM and the index/bank registers stay in round_sequencer.

Test Plan:
- Run with NROUNDS=2, NSTEPS=3, engines echoing done 1 cycle after start.
  - step_start sequence is 001,010,100,001,010,100; round goes 0,0,0,1,1,1.
  - done appears exactly 19 cycles after the start edge.
  - Final bank_sel=0; busy is high throughout.
- Engine 1 delays done by 50 cycles.
  - WAIT lasts 50 cycles; no fault; ordering is unchanged.
  - Total is 49 cycles longer than the first test.
- TIMEOUT=8 and engine 0 never answers.
  - fault rises 8 cycles after LAUNCH; busy=0; round=0, step=0 frozen.
  - start is ignored; abort clears fault and returns to IDLE.
- Inject step_done[2] while step=0.
  - No advance; the sequencer still waits for bit 0.
- abort mid-round (round=1, step=1).
  - Next cycle is IDLE; step_start=0; no done pulse.
  - A new start then replays from round 0, bank_sel=0.
- Assert rst during WAIT; start held high across it and while busy.
  - All outputs are 0 immediately after rst.
  - After release, exactly one permutation runs; the extra start is not queued.
